alu_ctrl_seq: RTL and testbench

- Registered, handshaked successor to the single-cycle ALU control decoder.
- Decodes ALUOp plus funct3/funct7 into a 5-bit ALU control code covering the full RV32I ALU set and RV32M.
- Holds the code in an output stage and sequences multi-cycle MUL/DIV ops with a latency counter, stalling upstream.
- Sits between the ID/EX pipeline register and the execute-stage ALU/muldiv unit.

---
 rtl/alu_ctrl_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder.
// Decodes ALUOp + funct3/funct7 into a 5-bit control code for RV32I and,
// optionally, RV32M. The code is held in an output stage. When RV32M is
// enabled, MUL/DIV ops hold the stage for a programmable latency before
// out_valid, and in_ready stalls upstream during that time.
//
// Optional feature macro: ALUCTRL_MEXT_EN (RV32M decode + multi-cycle WAIT).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 sync kill of held/in-flight op (highest priority)
//   in_valid / in_ready   upstream handshake (instrucao, ALUOp)
//   instrucao[31:0]       instruction word, funct3=[14:12], funct7=[31:25]
//   ALUOp[1:0]            00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//   out_valid / out_ready downstream handshake
//   alu_ctrl[CTRL_W-1:0]  registered control code
//   illegal               registered: decode had no legal mapping
//   mc_busy               multi-cycle wait in progress
module alu_ctrl_seq #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CTRL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instrucao,
  input  logic [1:0]        ALUOp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              mc_busy
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CODE_W-1:0] C_AND  = 5'b00000;
  localparam logic [CODE_W-1:0] C_OR   = 5'b00001;
  localparam logic [CODE_W-1:0] C_ADD  = 5'b00010;
  localparam logic [CODE_W-1:0] C_XOR  = 5'b00011;
  localparam logic [CODE_W-1:0] C_SLL  = 5'b00100;
  localparam logic [CODE_W-1:0] C_SRL  = 5'b00101;
  localparam logic [CODE_W-1:0] C_SUB  = 5'b00110;
  localparam logic [CODE_W-1:0] C_SRA  = 5'b00111;
  localparam logic [CODE_W-1:0] C_SLT  = 5'b01000;
  localparam logic [CODE_W-1:0] C_SLTU = 5'b01001;

  // Elaboration-time parameter range check
  if (CTRL_W < 5 || MUL_LAT > 255 || DIV_LAT > 255) begin : g_param_check
    $error("alu_ctrl_seq: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [CODE_W-1:0] base_code;
  logic [CODE_W-1:0] dec_code;
  logic              dec_ill;
  logic              accept;
  logic              cap;
  logic              go_wait;
  logic              wait_done;
  logic              unused_instr;

  assign funct3       = instrucao[14:12];
  assign funct7       = instrucao[31:25];
  assign unused_instr = ^{instrucao[24:15], instrucao[11:0]};

  // Base R/I-type mapping from funct3 (funct7 = 0000000)
  always_comb begin
    base_code = C_ADD;
    case (funct3)
      3'b000:  base_code = C_ADD;
      3'b001:  base_code = C_SLL;
      3'b010:  base_code = C_SLT;
      3'b011:  base_code = C_SLTU;
      3'b100:  base_code = C_XOR;
      3'b101:  base_code = C_SRL;
      3'b110:  base_code = C_OR;
      default: base_code = C_AND;
    endcase
  end

  // Full decode; every illegal combination falls back to ADD
  always_comb begin
    dec_code = C_ADD;
    dec_ill  = 1'b0;
    case (ALUOp)
      2'b00: dec_code = C_ADD;
      2'b01: begin
        case (funct3[2:1])
          2'b00:   dec_code = C_SUB;
          2'b10:   dec_code = C_SLT;
          2'b11:   dec_code = C_SLTU;
          default: dec_ill  = 1'b1;
        endcase
      end
      2'b10: begin
        case (funct7)
          7'b0000000: dec_code = base_code;
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_code = C_SUB;
            else if (funct3 == 3'b101) dec_code = C_SRA;
            else                       dec_ill  = 1'b1;
          end
`ifdef ALUCTRL_MEXT_EN
          7'b0000001: dec_code = {2'b10, funct3};
`endif
          default:    dec_ill = 1'b1;
        endcase
      end
      default: begin
        case (funct3)
          3'b001: begin
            if (funct7 == 7'b0000000) dec_code = C_SLL;
            else                      dec_ill  = 1'b1;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      dec_code = C_SRL;
            else if (funct7 == 7'b0100000) dec_code = C_SRA;
            else                           dec_ill  = 1'b1;
          end
          default: dec_code = base_code;
        endcase
      end
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALUCTRL_MEXT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_mul;
  logic             is_div;

  assign is_mul    = (dec_code[4:2] == 3'b100);
  assign is_div    = (dec_code[4:2] == 3'b101);
  assign go_wait   = (is_mul && (MUL_LAT != 0)) || (is_div && (DIV_LAT != 0));
  assign wait_done = (cnt_q == '0);
  assign mc_busy   = (state_q == S_WAIT);

  // Latency counter: loaded with LAT-1 on a multi-cycle accept
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      if (!wait_done) cnt_d = cnt_q - CNT_W'(1);
    end else if (cap && go_wait) begin
      cnt_d = is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign go_wait   = 1'b0;
  assign wait_done = 1'b1;
  assign mc_busy   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and capture strobe
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            cap     = 1'b1;
            state_d = go_wait ? S_WAIT : S_FULL;
          end
        end
        S_WAIT: begin
          if (wait_done) state_d = S_FULL;
        end
        S_FULL: begin
          // in_ready follows out_ready here, so accept implies a drain
          if (accept) begin
            cap     = 1'b1;
            state_d = go_wait ? S_WAIT : S_FULL;
          end else if (out_ready) begin
            state_d = S_EMPTY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign in_ready  = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);

  // Output stage: code and illegal flag only change on a committed accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= '0;
      illegal  <= 1'b0;
    end else if (cap) begin
      alu_ctrl <= CTRL_W'(dec_code);
      illegal  <= dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instrucao;
  logic [1:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_ctrl;
  logic        illegal;
  logic        mc_busy;

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CTRL_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instrucao (instrucao),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .mc_busy   (mc_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: held op plus remaining wait cycles
  bit         m_full;
  int         m_wait;
  logic [4:0] m_code;
  logic       m_ill;

  localparam logic [4:0] RTYPE_TBL [8] = '{5'd2, 5'd4, 5'd8, 5'd9, 5'd3, 5'd5, 5'd1, 5'd0};

  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3,
                                     output logic [4:0] code, output logic ill);
    code = 5'd2;
    ill  = 1'b0;
    if (op == 2'd1) begin
      if (f3 <= 3'd1)      code = 5'd6;
      else if (f3 <= 3'd3) ill  = 1'b1;
      else if (f3 <= 3'd5) code = 5'd8;
      else                 code = 5'd9;
    end else if (op == 2'd2) begin
      if (f7 == 7'h00) code = RTYPE_TBL[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 5'd6;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 5'd7;
`ifdef ALUCTRL_MEXT_EN
      else if (f7 == 7'h01) code = 5'd16 + 5'(f3);
`endif
      else ill = 1'b1;
    end else if (op == 2'd3) begin
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20) code = 5'd7;
      else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
      else code = RTYPE_TBL[f3];
    end
  endfunction

  function automatic int ref_lat(input logic [4:0] code);
`ifdef ALUCTRL_MEXT_EN
    if (code >= 5'd16 && code <= 5'd19) return int'(MUL_LAT);
    if (code >= 5'd20 && code <= 5'd23) return int'(DIV_LAT);
`endif
    if (code == 5'h1f) return 1;
    return 0;
  endfunction

  // One cycle: compare outputs, drive inputs, advance model, cross the edge
  task automatic step(input bit v, input logic [1:0] op, input logic [6:0] f7,
                      input logic [2:0] f3, input bit ordy, input bit fl);
    logic [31:0] ins;
    bit          exp_rdy;
    bit          acc;
    int          lat;
    check("out_valid", out_valid, m_full);
    check("mc_busy", mc_busy, m_wait > 0);
    check("alu_ctrl", alu_ctrl, m_code);
    check("illegal", illegal, m_ill);
    ins         = $urandom;
    ins[31:25]  = f7;
    ins[14:12]  = f3;
    instrucao   = ins;
    ALUOp       = op;
    in_valid    = v;
    out_ready   = ordy;
    flush       = fl;
    #1;
    exp_rdy = (m_wait == 0) && (!m_full || ordy);
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy && !fl;
    if (fl) begin
      m_full = 0;
      m_wait = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_full = 1;
    end else begin
      if (m_full && ordy) m_full = 0;
      if (acc) begin
        ref_decode(op, f7, f3, m_code, m_ill);
        lat = ref_lat(m_code);
        if (lat > 0) begin
          m_wait = lat;
          m_full = 0;
        end else begin
          m_full = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 7'd0, 3'd0, 1, 0);
  endtask

  task automatic model_reset();
    m_full = 0;
    m_wait = 0;
    m_code = 5'd0;
    m_ill  = 1'b0;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; instrucao = '0; ALUOp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_ctrl", alu_ctrl, 5'b00000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mc_busy", mc_busy, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Streamed R-type ops, no bubbles
    step(1, 2'd2, 7'h00, 3'd0, 1, 0);
    check("stream_add", alu_ctrl, 5'b00010);
    step(1, 2'd2, 7'h20, 3'd0, 1, 0);
    check("stream_sub", alu_ctrl, 5'b00110);
    check("stream_sub_v", out_valid, 1'b1);
    step(1, 2'd2, 7'h00, 3'd7, 1, 0);
    check("stream_and", alu_ctrl, 5'b00000);
    step(1, 2'd2, 7'h00, 3'd6, 1, 0);
    check("stream_or", alu_ctrl, 5'b00001);
    check("stream_or_v", out_valid, 1'b1);
    idle(1);

    // Backpressure on I-type SRA
    step(1, 2'd3, 7'h20, 3'd5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd2, 7'h00, 3'd4, 0, 0);
      check("bp_hold", alu_ctrl, 5'b00111);
    end
    step(1, 2'd2, 7'h00, 3'd4, 1, 0);
    check("bp_next", alu_ctrl, 5'b00011);
    idle(1);

    // Illegal decode
    step(1, 2'd2, 7'h20, 3'd7, 1, 0);
    check("ill_code", alu_ctrl, 5'b00010);
    check("ill_flag", illegal, 1'b1);
    idle(1);

    // MUL latency
    step(1, 2'd2, 7'h01, 3'd0, 1, 0);
`ifdef ALUCTRL_MEXT_EN
    check("mul_busy1", mc_busy, 1'b1);
    check("mul_nv1", out_valid, 1'b0);
    idle(1);
    check("mul_busy2", mc_busy, 1'b1);
    idle(1);
    check("mul_valid", out_valid, 1'b1);
    check("mul_code", alu_ctrl, 5'b10000);
    check("mul_busy_off", mc_busy, 1'b0);
`else
    check("mul_noext_code", alu_ctrl, 5'b00010);
    check("mul_noext_ill", illegal, 1'b1);
    check("mul_noext_v", out_valid, 1'b1);
`endif
    idle(1);

    // DIVU flushed mid-wait; same-cycle accept is dropped
    step(1, 2'd2, 7'h01, 3'd5, 1, 0);
    idle(9);
    step(1, 2'd2, 7'h00, 3'd4, 1, 1);
    check("flush_v", out_valid, 1'b0);
    check("flush_busy", mc_busy, 1'b0);
    check("flush_rdy", in_ready, 1'b1);
`ifdef ALUCTRL_MEXT_EN
    check("flush_keep", alu_ctrl, 5'b10101);
`endif
    idle(3);

    // Async reset in the middle of a long op
    step(1, 2'd2, 7'h01, 3'd4, 1, 0);
    idle(2);
    in_valid = 0; flush = 0;
    rst_n = 0;
    #2;
    check("arst_v", out_valid, 1'b0);
    check("arst_busy", mc_busy, 1'b0);
    check("arst_code", alu_ctrl, 5'b00000);
    check("arst_ill", illegal, 1'b0);
    model_reset();
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] f7;
      int         r;
      r = $urandom_range(0, 7);
      if (r < 3)      f7 = 7'h00;
      else if (r < 5) f7 = 7'h20;
      else if (r < 7) f7 = 7'h01;
      else            f7 = 7'($urandom);
      step($urandom_range(0, 9) < 7, 2'($urandom), f7, 3'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
